// File: rtl/motor_cmd_shaper.sv
// motor_cmd_shaper: slew-limits two signed wheel-speed commands on a fixed update tick and
// maps each ramped speed onto the sign/period pair consumed by motor_controller.
module motor_cmd_shaper #(
  parameter int unsigned TICK_DIV      = 50000,
  parameter int unsigned RAMP_STEP     = 4,
  parameter int unsigned TIMEOUT_TICKS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_m1,
  input  logic [7:0] cmd_m2,
  output logic       motor1_sign,
  output logic [6:0] motor1_period,
  output logic       motor2_sign,
  output logic [6:0] motor2_period,
  output logic       timeout
);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [WW-1:0]     WD_MAX    = WW'(TIMEOUT_TICKS - 1);
  localparam logic signed [8:0] STEP9     = 9'(RAMP_STEP);
  localparam logic signed [7:0] STEP8     = 8'(RAMP_STEP);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  // -128 has no positive counterpart, so it is pulled in to keep speeds symmetric.
  function automatic logic signed [7:0] f_clamp(input logic [7:0] v);
    return (v == 8'h80) ? 8'sh81 : $signed(v);
  endfunction

  function automatic logic signed [7:0] f_ramp(input logic signed [7:0] tgt,
                                               input logic signed [7:0] cur);
    logic signed [8:0] d;
    d = $signed({tgt[7], tgt}) - $signed({cur[7], cur});
    if ((d <= STEP9) && (d >= -STEP9)) begin
      return tgt;
    end else if (!d[8]) begin
      return cur + STEP8;
    end else begin
      return cur - STEP8;
    end
  endfunction

  function automatic logic [6:0] f_period(input logic signed [7:0] cur);
    logic [6:0] mag;
    mag = cur[7] ? 7'(-cur) : cur[6:0];
    return 7'd127 - mag;
  endfunction

  logic [PW-1:0]     r_presc;
  logic [WW-1:0]     r_wd;
  logic [1:0]        r_state;
  logic              r_rdy_en;
  logic              r_timeout;
  logic signed [7:0] r_tgt1, r_tgt2, r_cur1, r_cur2;
  logic              r_sign1, r_sign2;
  logic [6:0]        r_per1, r_per2;
  logic              w_tick;
  logic              w_accept;

  assign w_tick    = (r_presc == PRESC_MAX);
  assign cmd_ready = r_rdy_en & ~w_tick;
  assign w_accept  = cmd_valid & cmd_ready;

  assign motor1_sign   = r_sign1;
  assign motor1_period = r_per1;
  assign motor2_sign   = r_sign2;
  assign motor2_period = r_per2;
  assign timeout       = r_timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc   <= '0;
      r_wd      <= '0;
      r_state   <= ST_IDLE;
      r_rdy_en  <= 1'b0;
      r_timeout <= 1'b0;
      r_tgt1    <= '0;
      r_tgt2    <= '0;
      r_cur1    <= '0;
      r_cur2    <= '0;
      r_sign1   <= 1'b1;
      r_sign2   <= 1'b1;
      r_per1    <= 7'd127;
      r_per2    <= 7'd127;
    end else begin
      r_rdy_en <= 1'b1;
      r_presc  <= w_tick ? '0 : r_presc + PW'(1);
      r_sign1  <= ~r_cur1[7];
      r_sign2  <= ~r_cur2[7];
      r_per1   <= f_period(r_cur1);
      r_per2   <= f_period(r_cur2);
      if (w_tick) begin
        r_cur1 <= f_ramp(r_tgt1, r_cur1);
        r_cur2 <= f_ramp(r_tgt2, r_cur2);
      end
      // Accept never coincides with a tick, so an accept always takes priority here.
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tgt1  <= f_clamp(cmd_m1);
            r_tgt2  <= f_clamp(cmd_m2);
            r_wd    <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_tgt1 <= f_clamp(cmd_m1);
            r_tgt2 <= f_clamp(cmd_m2);
            r_wd   <= '0;
          end else if (w_tick) begin
            if (r_wd == WD_MAX) begin
              r_state   <= ST_TIMEOUT;
              r_timeout <= 1'b1;
              r_tgt1    <= '0;
              r_tgt2    <= '0;
              r_wd      <= '0;
            end else begin
              r_wd <= r_wd + WW'(1);
            end
          end
        end
        ST_TIMEOUT: begin
          if (w_accept) begin
            r_tgt1    <= f_clamp(cmd_m1);
            r_tgt2    <= f_clamp(cmd_m2);
            r_wd      <= '0;
            r_timeout <= 1'b0;
            r_state   <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_motor_cmd_shaper.sv
// Directed bench for motor_cmd_shaper with TICK_DIV=4, RAMP_STEP=4, TIMEOUT_TICKS=3.
module tb_motor_cmd_shaper;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_m1 = 8'd0;
  logic [7:0] cmd_m2 = 8'd0;
  logic       cmd_ready, motor1_sign, motor2_sign, timeout;
  logic [6:0] motor1_period, motor2_period;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;

  motor_cmd_shaper #(
    .TICK_DIV     (4),
    .RAMP_STEP    (4),
    .TIMEOUT_TICKS(3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_m1       (cmd_m1),
    .cmd_m2       (cmd_m2),
    .motor1_sign  (motor1_sign),
    .motor1_period(motor1_period),
    .motor2_sign  (motor2_sign),
    .motor2_period(motor2_period),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  // cyc counts edges since reset release; prescaler equals cyc % 4, tick when it is 3.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic to_tick();
    while (cyc % 4 != 3) step();
  endtask

  task automatic send(input logic [7:0] m1, input logic [7:0] m2);
    if (cyc % 4 == 3) step();
    cmd_valid = 1'b1;
    cmd_m1 = m1;
    cmd_m2 = m2;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic assert_reset_mid_cycle();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    step();
  endtask

  task automatic test_reset();
    step(); step();
    assert_reset_mid_cycle();
    checks++;
    if ({motor1_sign, motor1_period, motor2_sign, motor2_period} !== {1'b1, 7'd127, 1'b1, 7'd127})
    begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h",
               {motor1_sign, motor1_period, motor2_sign, motor2_period}, 16'hFFFF);
    end
    checks++;
    if ({timeout, cmd_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_timeout_ready got=%b exp=00", {timeout, cmd_ready});
    end
    release_reset();
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_release got=%b exp=1", cmd_ready);
    end
    step(); step();
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++; $display("FAIL ready_low_on_tick got=%b exp=0", cmd_ready);
    end
  endtask

  task automatic test_basic_ramp();
    int prev, e;
    send(8'd20, 8'd0);
    for (int k = 0; k < 7; k++) begin
      prev = (k <= 5) ? 127 - 4 * k : 107;
      e = (k < 5) ? 123 - 4 * k : 107;
      to_tick(); step();
      checks++;
      if (motor1_period !== 7'(prev)) begin
        failures++; $display("FAIL ramp_latency k=%0d got=%0d exp=%0d", k, motor1_period, prev);
      end
      step();
      checks++;
      if ({motor1_sign, motor1_period} !== {1'b1, 7'(e)}) begin
        failures++;
        $display("FAIL ramp_m1 k=%0d got=%b/%0d exp=1/%0d", k, motor1_sign, motor1_period, e);
      end
      checks++;
      if ({motor2_sign, motor2_period} !== {1'b1, 7'd127}) begin
        failures++;
        $display("FAIL ramp_m2 k=%0d got=%b/%0d exp=1/127", k, motor2_sign, motor2_period);
      end
      send(8'd20, 8'd0);
    end
  endtask

  task automatic test_clamp_reverse();
    int cur;
    logic es;
    logic [6:0] ep;
    for (int k = 1; k <= 4; k++) begin
      send(8'd6, 8'd0);
      to_tick(); step(); step();
      cur = (k < 4) ? 20 - 4 * k : 6;
      checks++;
      if ({motor1_sign, motor1_period} !== {1'b1, 7'(127 - cur)}) begin
        failures++;
        $display("FAIL settle6 k=%0d got=%b/%0d exp=1/%0d", k, motor1_sign, motor1_period,
                 127 - cur);
      end
    end
    for (int k = 1; k <= 35; k++) begin
      send(8'h80, 8'd0);
      to_tick(); step(); step();
      cur = 6 - 4 * k;
      if (cur < -127) cur = -127;
      es = (cur >= 0);
      ep = 7'(127 - ((cur < 0) ? -cur : cur));
      checks++;
      if ({motor1_sign, motor1_period} !== {es, ep}) begin
        failures++;
        $display("FAIL reverse k=%0d got=%b/%0d exp=%b/%0d", k, motor1_sign, motor1_period,
                 es, ep);
      end
    end
    checks++;
    if ({motor1_sign, motor1_period} !== {1'b0, 7'd0}) begin
      failures++;
      $display("FAIL clamp_final got=%b/%0d exp=0/0", motor1_sign, motor1_period);
    end
  endtask

  task automatic test_handshake_hold();
    to_tick();
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++; $display("FAIL hold_ready_tick got=%b exp=0", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_m1 = 8'h9C;
    cmd_m2 = 8'd0;
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL hold_ready_after got=%b exp=1", cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
    to_tick(); step(); step();
    checks++;
    if ({motor1_sign, motor1_period} !== {1'b0, 7'd4}) begin
      failures++;
      $display("FAIL hold_applied got=%b/%0d exp=0/4", motor1_sign, motor1_period);
    end
  endtask

  task automatic test_reset_mid_ramp();
    assert_reset_mid_cycle();
    release_reset();
    send(8'd40, 8'hD8);
    for (int k = 1; k <= 3; k++) begin
      to_tick(); step(); step();
      checks++;
      if ({motor1_sign, motor1_period, motor2_sign, motor2_period} !==
          {1'b1, 7'(127 - 4 * k), 1'b0, 7'(127 - 4 * k)}) begin
        failures++;
        $display("FAIL midramp k=%0d got=%b/%0d %b/%0d exp=1/%0d 0/%0d", k, motor1_sign,
                 motor1_period, motor2_sign, motor2_period, 127 - 4 * k, 127 - 4 * k);
      end
      if (k < 3) send(8'd40, 8'hD8);
    end
    assert_reset_mid_cycle();
    checks++;
    if ({motor1_sign, motor1_period, motor2_sign, motor2_period} !== {1'b1, 7'd127, 1'b1, 7'd127})
    begin
      failures++;
      $display("FAIL midramp_reset got=%b/%0d %b/%0d exp=1/127 1/127", motor1_sign,
               motor1_period, motor2_sign, motor2_period);
    end
    release_reset();
    for (int k = 0; k < 5; k++) begin
      to_tick(); step(); step();
      checks++;
      if ({motor1_sign, motor1_period, motor2_sign, motor2_period, timeout} !==
          {1'b1, 7'd127, 1'b1, 7'd127, 1'b0}) begin
        failures++;
        $display("FAIL idle_still k=%0d got=%b/%0d %b/%0d to=%b exp=1/127 1/127 to=0", k,
                 motor1_sign, motor1_period, motor2_sign, motor2_period, timeout);
      end
    end
  endtask

  task automatic test_watchdog();
    for (int k = 0; k < 5; k++) begin
      send(8'd20, 8'd0);
      to_tick(); step(); step();
      checks++;
      if (motor1_period !== 7'(123 - 4 * k)) begin
        failures++;
        $display("FAIL wd_settle k=%0d got=%0d exp=%0d", k, motor1_period, 123 - 4 * k);
      end
    end
    to_tick(); step();
    checks++;
    if (timeout !== 1'b0) begin
      failures++; $display("FAIL wd_early got=%b exp=0", timeout);
    end
    to_tick(); step();
    checks++;
    if ({timeout, motor1_period} !== {1'b1, 7'd107}) begin
      failures++;
      $display("FAIL wd_fire got=%b/%0d exp=1/107", timeout, motor1_period);
    end
    for (int k = 1; k <= 5; k++) begin
      to_tick(); step(); step();
      checks++;
      if ({motor1_sign, motor1_period, timeout} !== {1'b1, 7'(107 + 4 * k), 1'b1}) begin
        failures++;
        $display("FAIL wd_rampdown k=%0d got=%b/%0d to=%b exp=1/%0d to=1", k, motor1_sign,
                 motor1_period, timeout, 107 + 4 * k);
      end
    end
    send(8'd8, 8'd0);
    checks++;
    if (timeout !== 1'b0) begin
      failures++; $display("FAIL wd_clear got=%b exp=0", timeout);
    end
    to_tick(); step(); step();
    checks++;
    if (motor1_period !== 7'd123) begin
      failures++; $display("FAIL wd_resume1 got=%0d exp=123", motor1_period);
    end
    send(8'd8, 8'd0);
    to_tick(); step(); step();
    checks++;
    if ({motor1_sign, motor1_period, timeout} !== {1'b1, 7'd119, 1'b0}) begin
      failures++;
      $display("FAIL wd_resume2 got=%b/%0d to=%b exp=1/119 to=0", motor1_sign, motor1_period,
               timeout);
    end
  endtask

  initial begin
    #12;
    release_reset();
    test_reset();
    test_basic_ramp();
    test_clamp_reverse();
    test_handshake_hold();
    test_reset_mid_ramp();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/motor_cmd_shaper.md
# motor_cmd_shaper

Upstream stage of `motor_controller`. It accepts signed 8-bit wheel-speed commands from the balance control loop through a valid/ready handshake and slew-limits each wheel toward its commanded speed on a fixed update tick. It converts each wheel's ramped speed into the `motorN_sign` / `motorN_period` pair that `motor_controller` consumes. A watchdog ramps both wheels to zero if the control loop stops sending commands.

## Interface
- `TICK_DIV`, default 50000: clk cycles per update tick (≥2).
- `RAMP_STEP`, default 4: maximum speed change per tick (1..127).
- `TIMEOUT_TICKS`, default 100: ticks without an accepted command before the watchdog fires (≥1).

- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command pair present.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `cmd_m1`  in  8  signed speed target, motor 1.
- `cmd_m2`  in  8  signed speed target, motor 2.
- `motor1_sign`  out  1  direction, motor 1 (1 = forward, speed ≥ 0).
- `motor1_period`  out  7  toggle period, motor 1 (smaller = faster).
- `motor2_sign`  out  1  direction, motor 2.
- `motor2_period`  out  7  toggle period, motor 2.
- `timeout`  out  1  watchdog fired; both targets forced to 0.

## Operation
- **Reset values:**
  - `cmd_ready`=0, `motorN_sign`=1, `motorN_period`=127, `timeout`=0.
  - Internal targets and current speeds = 0; prescaler and watchdog count = 0.
  - State = IDLE.
- **Prescaler:** counts 0..TICK_DIV-1 and wraps. `tick` is high in the cycle where the count equals TICK_DIV-1.
- **Ready:** `cmd_ready` = not in reset and `!tick`. It is a pure function of registers.
- **Accept:** occurs when `cmd_valid & cmd_ready`.
  - Each command is clamped: -128 becomes -127.
  - The clamped values are stored as target1/target2.
  - The watchdog count is cleared on accept.
  - While `cmd_ready`=0, the command stays pending and the source must hold it.
- **State machine:**
  - IDLE → RUN on the first accept. In IDLE the watchdog is not running.
  - RUN: the watchdog increments on each tick. On a tick with count == TIMEOUT_TICKS-1 → TIMEOUT.
  - Entering TIMEOUT sets `timeout`=1, forces both targets to 0 and resets the count.
  - TIMEOUT → RUN on an accept. `timeout` clears and the new targets load in that same cycle.
- **Ramp (on tick only):** per motor, compute the difference d = target − current in 9-bit signed arithmetic.
  - If |d| ≤ RAMP_STEP, current ← target.
  - Otherwise current ← current ± RAMP_STEP.
  - Current never leaves the range −127..127.
- **Mapping (registered, the cycle after current updates):**
  - sign = (current ≥ 0).
  - period = 127 − |current|. So speed 0 → 127 and ±127 → 0.
- **Simultaneous events:**
  - Accept and tick cannot coincide because ready is low on the tick cycle.
  - A watchdog expiry and an incoming command on the same tick: the expiry wins. The command is accepted next cycle and exits TIMEOUT.
- **Reset mid-operation:** all state returns to the reset values immediately (asynchronously). The outputs present speed 0 (sign 1, period 127).

## Timing
- Tick period = TICK_DIV cycles. The first tick occurs TICK_DIV cycles after reset release.
- Output latency: outputs reflect the updated current 1 cycle after the tick cycle.
  - Example: tick in cycle T, current updates at the edge ending T, outputs change at the edge ending T+1.
- From an accept to the first output change is at most TICK_DIV+1 cycles.
- Full ramp from 0 to ±127 takes ceil(127/RAMP_STEP) ticks.
- `timeout` asserts at the edge ending the TIMEOUT_TICKS-th tick after the last accept.
- Outputs are stable between ticks, so `motor_controller` sees at most one change per TICK_DIV cycles.

## Test plan
- **Reset values:** assert `reset` mid-cycle with a clock running → outputs immediately show sign 1, period 127, `timeout` 0, `cmd_ready` 0. After release, `cmd_ready` = 1 from the first edge.
- **Basic ramp** (TICK_DIV=4, RAMP_STEP=4, `cmd_m1`=20, `cmd_m2`=0) → `motor1_period` steps 123, 119, 115, 111, 107 on 5 consecutive ticks and then holds. `motor1_sign`=1 throughout; motor 2 stays at period 127.
- **Clamp and direction reversal:** `cmd_m1`=6 settled, then `cmd_m1`=-128 with RAMP_STEP=4 → current goes 2, −2, −6, … and saturates at −127. Required outputs:
  - sign 1 at current=2, sign 0 from current=−2 onward.
  - Final period 0, sign 0.
- **Handshake hold:** present `cmd_valid` in the tick cycle → `cmd_ready`=0, no acceptance. The command is accepted one cycle later with unchanged data.
- **Watchdog** (TIMEOUT_TICKS=3, target 20 settled, no further commands) → `timeout`=1 after the 3rd tick. Period then ramps 111, 115, … back to 127. A new accept of 8 clears `timeout` in the same cycle and the ramp heads to period 119.
- **Reset mid-ramp:** reset while current=12 and target=40 → outputs return to period 127, sign 1 immediately. After release, no motion until a new command is accepted.
